register_nb: RTL and testbench
==============================

# register_nb

Parametrised general-purpose register for the 8-bit CPU datapath, the next generation of the 4-bit D-register. It holds a WIDTH-bit value and, when both active-low gates are asserted, performs one of several synchronous operations per clock: load, increment, decrement, shift or clear. The value drives the shared bus through a tri-state output controlled by two disable inputs, and is also always visible on an internal port with carry and zero flags. It serves as the accumulator, the B register, the program counter and the memory address register.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- RESET_VAL, 0, value of R after reset (WIDTH bits)

- CLK  in  1  clock; all state changes on the rising edge
- CLR_n  in  1  reset; synchronous, active-low
- G1_n  in  1  gate enable 1, active-low
- G2_n  in  1  gate enable 2, active-low
- MODE  in  3  operation select, sampled at the clock edge
- M  in  1  output disable; high floats Q
- N  in  1  output disable; high floats Q
- D  in  WIDTH  parallel load data
- SI  in  1  serial input for shifts
- Q  out  WIDTH  tri-state bus output
- R  out  WIDTH  register value, always driven
- CO  out  1  registered carry, borrow or shift-out flag
- Z  out  1  high when R == 0 (combinational)

## Operation
- Enable: the register acts only when G1_n == 0 and G2_n == 0. Otherwise R and CO hold.
- MODE encoding when enabled:
  - 000 HOLD: R and CO unchanged.
  - 001 LOAD: R ← D, CO ← 0.
  - 010 INC: R ← R+1 modulo 2^WIDTH. CO ← 1 only when old R was all-ones, so R wraps to 0.
  - 011 DEC: R ← R−1 modulo 2^WIDTH. CO ← 1 only when old R was 0, so R wraps to all-ones.
  - 100 SHL: R ← {R[WIDTH-2:0], SI}, CO ← old R[WIDTH-1].
  - 101 SHR: R ← {SI, R[WIDTH-1:1]}, CO ← old R[0].
  - 110 CLEAR: R ← 0, CO ← 0.
  - 111 reserved: behaves as HOLD.
- Output: Q = R when M == 0 and N == 0. Otherwise Q = all-Z. R is unaffected by M and N.
- Z is derived from the current R and ignores M and N.

## Timing
- Reset: CLR_n low at a rising edge sets R = RESET_VAL and CO = 0.
  - Reset has priority over the gates and MODE, including mid-count or mid-shift.
  - Q follows R, so Q = RESET_VAL if output is enabled, else Z.
  - Z = (RESET_VAL == 0).
- Latency: one cycle from the sampled inputs to R and CO. Q and Z are combinational from R and M/N, with zero additional cycles.
- Gates, MODE, D and SI are sampled only at the rising edge. Changes between edges have no effect.
- Back-to-back operations are allowed every cycle; each uses the R produced by the previous edge.
- Simultaneous CLR_n low and a gated operation: reset wins and the operation is discarded.
- M and N toggling has no effect on stored state. A LOAD with M = 1 still updates R.

## Configuration
- REG_SHIFT_EN defined: modes 100 and 101 shift as above, and SI is used.
- REG_SHIFT_EN undefined: modes 100 and 101 behave as HOLD (R and CO unchanged), and SI is ignored (port kept).

## Structure
- Package reg_pkg: the mode localparams MODE_HOLD, MODE_LOAD, MODE_INC, MODE_DEC, MODE_SHL, MODE_SHR and MODE_CLEAR, plus the 3-bit mode typedef.
- Sub-module register_nb_next: a combinational next-value and next-CO unit taking R, D, SI and MODE. It holds the REG_SHIFT_EN guards.
- The top level holds the state flops, reset, gating, tri-state driver and zero flag.

## Test plan
All scenarios use WIDTH = 8 and RESET_VAL = 0.
- Reset: CLR_n = 0 for one edge with gates enabled and MODE = LOAD, D = 0xA5 → R = 0x00, CO = 0, Z = 1, Q = 0x00.
- Gate and output control:
  - LOAD D = 0x3C with G1_n = 1 → R stays 0x00.
  - Same with G1_n = G2_n = 0 → R = 0x3C.
  - Set M = 1 → Q = ZZZZZZZZ while R = 0x3C.
  - Set N = 1, M = 0 → Q = Z.
  - Clear both → Q = 0x3C.
- Increment wrap: LOAD 0xFE, then INC twice → R = 0xFF with CO = 0, then R = 0x00 with CO = 1 and Z = 1.
- Decrement wrap: from 0x00, DEC → R = 0xFF, CO = 1; a second DEC → R = 0xFE, CO = 0.
- Shifts (REG_SHIFT_EN defined):
  - LOAD 0x81, SHL with SI = 0 → R = 0x02, CO = 1.
  - SHR with SI = 1 → R = 0x81, CO = 0.
  - Rebuilt without the macro, the same sequence → R stays 0x81 and CO stays 0.
- Reset mid-count: INC every cycle from 0x10, assert CLR_n = 0 on the third edge → R = 0x00 at that edge, not 0x13. INC resumes from 0x00 the next cycle.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared mode encoding for the register_nb general-purpose register.
package reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_LOAD  = 3'b001;
  localparam mode_t MODE_INC   = 3'b010;
  localparam mode_t MODE_DEC   = 3'b011;
  localparam mode_t MODE_SHL   = 3'b100;
  localparam mode_t MODE_SHR   = 3'b101;
  localparam mode_t MODE_CLEAR = 3'b110;

endpackage

// File: rtl/register_nb_next.sv
// Combinational next-value / next-flag unit for register_nb.
// Shift modes exist only when REG_SHIFT_EN is defined; otherwise they hold.
module register_nb_next
  import reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             co,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  input  mode_t            mode,
  output logic [WIDTH-1:0] r_next,
  output logic             co_next
);

`ifndef REG_SHIFT_EN
  logic unused_si;
  assign unused_si = si;
`endif

  // Select the operation result; reserved and unknown modes hold.
  always_comb begin
    r_next  = r;
    co_next = co;
    case (mode)
      MODE_HOLD: begin
        r_next  = r;
        co_next = co;
      end
      MODE_LOAD: begin
        r_next  = d;
        co_next = 1'b0;
      end
      MODE_INC: begin
        r_next  = r + {{(WIDTH-1){1'b0}}, 1'b1};
        co_next = &r;
      end
      MODE_DEC: begin
        r_next  = r - {{(WIDTH-1){1'b0}}, 1'b1};
        co_next = ~|r;
      end
`ifdef REG_SHIFT_EN
      MODE_SHL: begin
        r_next  = {r[WIDTH-2:0], si};
        co_next = r[WIDTH-1];
      end
      MODE_SHR: begin
        r_next  = {si, r[WIDTH-1:1]};
        co_next = r[0];
      end
`endif
      MODE_CLEAR: begin
        r_next  = {WIDTH{1'b0}};
        co_next = 1'b0;
      end
      default: begin
        r_next  = r;
        co_next = co;
      end
    endcase
  end

endmodule

// File: rtl/register_nb.sv
// Gated general-purpose datapath register with tri-state bus output and flags.
// Optional feature macro: REG_SHIFT_EN (enables SHL/SHR modes).
module register_nb
  import reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             G1_n,
  input  logic             G2_n,
  input  logic [2:0]       MODE,
  input  logic             M,
  input  logic             N,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output tri   [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             CO,
  output logic             Z
);

  logic [WIDTH-1:0] r_r;
  logic             co_r;
  logic [WIDTH-1:0] r_next_s;
  logic             co_next_s;

  register_nb_next #(.WIDTH(WIDTH)) u_next (
    .r       (r_r),
    .co      (co_r),
    .d       (D),
    .si      (SI),
    .mode    (mode_t'(MODE)),
    .r_next  (r_next_s),
    .co_next (co_next_s)
  );

  // State update: reset outranks the gates, which must both be low to act.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      r_r  <= RESET_VAL;
      co_r <= 1'b0;
    end else if (!G1_n && !G2_n) begin
      r_r  <= r_next_s;
      co_r <= co_next_s;
    end else begin
      r_r  <= r_r;
      co_r <= co_r;
    end
  end

  assign R  = r_r;
  assign CO = co_r;
  assign Z  = (r_r == {WIDTH{1'b0}});
  assign Q  = (!M && !N) ? r_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_nb.sv
// Self-checking bench for register_nb (WIDTH=8, RESET_VAL=0): per-cycle model compare plus literal checks.
module tb_register_nb;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       g1_n = 1'b1;
  logic       g2_n = 1'b1;
  logic [2:0] mode = 3'b000;
  logic       m = 1'b0;
  logic       n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       si = 1'b0;
  wire  [7:0] q;
  logic [7:0] r;
  logic       co;
  logic       z;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int  m_r = 0;
  int  m_co = 0;
  bit  m_valid = 1'b0;

  // A floated bus reads as all-ones through these pull-ups.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (q[i]);
  end

  register_nb #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK(clk), .CLR_n(clr_n), .G1_n(g1_n), .G2_n(g2_n), .MODE(mode),
    .M(m), .N(n), .D(d), .SI(si), .Q(q), .R(r), .CO(co), .Z(z)
  );

  always #5 clk = ~clk;

  // Model: apply the operation rules arithmetically on every rising edge.
  always @(posedge clk) begin
    if (!clr_n) begin
      m_r = 0; m_co = 0; m_valid = 1'b1;
    end else if (!g1_n && !g2_n) begin
      case (mode)
        3'd1: begin m_r = d; m_co = 0; end
        3'd2: begin m_co = (m_r == 255) ? 1 : 0; m_r = (m_r + 1) % 256; end
        3'd3: begin m_co = (m_r == 0) ? 1 : 0; m_r = (m_r + 255) % 256; end
`ifdef REG_SHIFT_EN
        3'd4: begin m_co = m_r / 128; m_r = (m_r * 2 + si) % 256; end
        3'd5: begin m_co = m_r % 2; m_r = m_r / 2 + si * 128; end
`endif
        3'd6: begin m_r = 0; m_co = 0; end
        default: ;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [7:0] eq;
      eq = (m || n) ? 8'hFF : m_r[7:0];
      checks++;
      if (r !== m_r[7:0] || co !== m_co[0] || z !== (m_r == 0) || q !== eq) begin
        failures++;
        $display("FAIL model_cmp t=%0t: R=%h CO=%b Z=%b Q=%h, required R=%h CO=%0d Z=%0d Q=%h",
                 $time, r, co, z, q, m_r[7:0], m_co, (m_r == 0), eq);
      end
    end
  end

  task automatic apply(input logic c, input logic ga, input logic gb,
                       input logic [2:0] md, input logic [7:0] dd, input logic s);
    clr_n = c; g1_n = ga; g2_n = gb; mode = md; d = dd; si = s;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [8:0] act, input logic [8:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  initial begin
    #2;
    // Reset with a pending LOAD
    apply(1'b0, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0);
    lit("reset_r", {co, r}, {1'b0, 8'h00});
    lit("reset_z", {8'h00, z}, 9'd1);
    lit("reset_q", {1'b0, q}, 9'h000);

    // Gating and output control
    apply(1'b1, 1'b1, 1'b0, 3'd1, 8'h3C, 1'b0);
    lit("gate_blocked", {1'b0, r}, 9'h000);
    apply(1'b1, 1'b0, 1'b0, 3'd1, 8'h3C, 1'b0);
    lit("gate_load", {1'b0, r}, 9'h03C);
    m = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    lit("m_float_q", {1'b0, q}, 9'h0FF);
    lit("m_float_r", {1'b0, r}, 9'h03C);
    m = 1'b0; n = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    lit("n_float_q", {1'b0, q}, 9'h0FF);
    n = 1'b0;
    #1;
    lit("q_restored", {1'b0, q}, 9'h03C);

    // Increment wrap
    apply(1'b1, 1'b0, 1'b0, 3'd1, 8'hFE, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    lit("inc_ff", {co, r}, {1'b0, 8'hFF});
    apply(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    lit("inc_wrap", {co, r}, {1'b1, 8'h00});
    lit("inc_wrap_z", {8'h00, z}, 9'd1);

    // Decrement wrap
    apply(1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0);
    lit("dec_wrap", {co, r}, {1'b1, 8'hFF});
    apply(1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0);
    lit("dec_fe", {co, r}, {1'b0, 8'hFE});

    // Shifts (hold when the shift feature is built out)
    apply(1'b1, 1'b0, 1'b0, 3'd1, 8'h81, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
`ifdef REG_SHIFT_EN
    lit("shl", {co, r}, {1'b1, 8'h02});
`else
    lit("shl_hold", {co, r}, {1'b0, 8'h81});
`endif
    apply(1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1);
    lit("shr", {co, r}, {1'b0, 8'h81});

    // Reserved mode holds, gate 2 blocks
    apply(1'b1, 1'b0, 1'b0, 3'd7, 8'h55, 1'b1);
    lit("reserved_hold", {co, r}, {1'b0, 8'h81});
    apply(1'b1, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    lit("g2_blocks_clear", {1'b0, r}, 9'h081);
    apply(1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0);
    lit("clear", {co, r}, {1'b0, 8'h00});

    // Reset mid-count
    apply(1'b1, 1'b0, 1'b0, 3'd1, 8'h10, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    lit("count_12", {1'b0, r}, 9'h012);
    apply(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    lit("reset_mid_count", {co, r}, {1'b0, 8'h00});
    apply(1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
    lit("resume_inc", {co, r}, {1'b0, 8'h01});

    // Mid-cycle input changes must not matter
    mode = 3'd6;
    #1;
    mode = 3'd0;
    apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    lit("between_edges", {1'b0, r}, 9'h001);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
